fft_out_serializer: RTL and testbench
=====================================

FFT_OUT_SERIALIZER -- requirements
Module: fft_out_serializer

Interface
REQ-001 SHALL have parameter N, default 32, FFT length (power of two, >=4).
REQ-002 SHALL have parameter MSB, default 16, bits per complex sample word.
REQ-003 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-004 SHALL have port rst_n  input  1  asynchronous active-low reset.
REQ-005 SHALL have port data_valid  input  1  one-cycle frame-ready pulse from the FFT stage.
REQ-006 SHALL have port fft_data_in  input  N*MSB  parallel FFT result; sample k at bits [k*MSB +: MSB].
REQ-007 SHALL have port out_ready  input  1  downstream accepts a word this cycle.
REQ-008 SHALL have port out_data  output  MSB  current sample word.
REQ-009 SHALL have port out_valid  output  1  out_data/out_index/out_last are valid.
REQ-010 SHALL have port out_index  output  $clog2(N)  source sample index k of out_data.
REQ-011 SHALL have port out_last  output  1  high with the final word of a frame.
REQ-012 SHALL have port busy  output  1  a frame is held or being streamed.
REQ-013 SHALL have port overrun  output  1  sticky flag: a frame was dropped.

Function
REQ-014 SHALL implement states IDLE and STREAM; busy is high exactly in STREAM.
REQ-015 In IDLE, data_valid high at an edge SHALL copy fft_data_in into an internal N*MSB shadow register, clear the word counter, enter STREAM.
REQ-016 out_valid SHALL be high the cycle after capture (latency 1), presenting word 0.
REQ-017 A transfer SHALL occur on an edge where out_valid and out_ready are both high; the counter then increments.
REQ-018 While out_valid is high and out_ready low, out_data, out_index, out_last SHALL hold stable.
REQ-019 out_last SHALL be high iff counter equals N-1 and out_valid is high.
REQ-020 On transfer of the last word the FSM SHALL return to IDLE and out_valid SHALL be low the next cycle, unless REQ-021 applies.
REQ-021 data_valid high on the same edge as the last-word transfer SHALL capture the new frame and stay in STREAM with counter 0 (back-to-back, no bubble, no overrun).
REQ-022 data_valid high in STREAM at any other edge SHALL be ignored (shadow untouched) and SHALL set overrun.
REQ-023 overrun SHALL remain set until reset.
REQ-024 Counter SHALL wrap from N-1 to 0 only via REQ-020/REQ-021; no partial-frame wrap.
REQ-025 fft_data_in changes after capture SHALL NOT affect streamed words.
REQ-026 out_data SHALL equal shadow word out_index, unmodified (no rounding, no width change).

Reset
REQ-027 rst_n low SHALL immediately force IDLE, counter 0, out_valid 0, out_last 0, busy 0, overrun 0, out_index 0, out_data 0, shadow register 0.
REQ-028 Reset mid-frame SHALL abandon the frame; first word after reset release appears only after a new data_valid.
REQ-029 data_valid on the first edge after rst_n rises SHALL be captured normally.

Configuration
REQ-030 Macro FFT_OUT_BITREV_EN defined: out_index SHALL be the bit-reverse of the counter (natural-order output from bit-reversed results).
REQ-031 Macro FFT_OUT_BITREV_EN undefined: out_index SHALL equal the counter.

Verification (N=32, MSB=16, macro undefined unless stated)
REQ-032 fft_data_in word k = 16'h1000+k, data_valid pulse, out_ready=1 -> 32 words 0x1000..0x101F on consecutive cycles from 1 cycle after pulse, out_last on word 31, out_valid low after.
REQ-033 Same frame, out_ready toggling 1/0 each cycle -> identical word sequence, outputs stable in stall cycles, 63 cycles total.
REQ-034 Second data_valid at word 10 -> overrun=1, stream continues 0x100A..0x101F unaffected; second pulse exactly on word 31 transfer -> new frame streams back-to-back, overrun stays 0.
REQ-035 rst_n low at word 5 -> all outputs 0 asynchronously, no further words until new data_valid.
REQ-036 FFT_OUT_BITREV_EN defined, word k = k -> out_index order 0,16,8,24,4,... and out_data equal to out_index each transfer.

Source files
------------

// File: rtl/fft_out_serializer.sv
// Serializes one parallel FFT result frame into a ready/valid word stream.
// Define FFT_OUT_BITREV_EN to emit words in bit-reversed index order.
module fft_out_serializer #(
  parameter int N   = 32,
  parameter int MSB = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 data_valid,
  input  logic [N*MSB-1:0]     fft_data_in,
  input  logic                 out_ready,
  output logic [MSB-1:0]       out_data,
  output logic                 out_valid,
  output logic [$clog2(N)-1:0] out_index,
  output logic                 out_last,
  output logic                 busy,
  output logic                 overrun
);
  localparam int LW = $clog2(N);

  typedef enum logic {IDLE, STREAM} state_t;

  state_t           state_q;
  logic [LW-1:0]    cnt_q;
  logic [N*MSB-1:0] shadow_q;
  logic             overrun_q;

  logic xfer;
  logic last;

  function automatic logic [LW-1:0] bitrev(input logic [LW-1:0] v);
    logic [LW-1:0] r;
    r = '0;
    for (int b = 0; b < LW; b++) r[b] = v[LW-1-b];
    return r;
  endfunction

  assign out_valid = (state_q == STREAM);
  assign busy      = (state_q == STREAM);
  assign overrun   = overrun_q;
  assign last      = (cnt_q == LW'(N-1));
  assign xfer      = out_valid && out_ready;
  assign out_last  = out_valid && last;

`ifdef FFT_OUT_BITREV_EN
  assign out_index = bitrev(cnt_q);
`else
  assign out_index = cnt_q;
`endif

  // Shadow and counter are both zero in reset, so out_data reads zero too.
  assign out_data = shadow_q[out_index*MSB +: MSB];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      shadow_q  <= '0;
      overrun_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (data_valid) begin
            shadow_q <= fft_data_in;
            cnt_q    <= '0;
            state_q  <= STREAM;
          end
        end
        STREAM: begin
          if (xfer && last) begin
            // A new frame landing on the final transfer chains without a bubble.
            cnt_q <= '0;
            if (data_valid) shadow_q <= fft_data_in;
            else            state_q  <= IDLE;
          end else begin
            if (xfer)       cnt_q     <= cnt_q + 1'b1;
            if (data_valid) overrun_q <= 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_fft_out_serializer.sv
// Directed checks for fft_out_serializer: streaming, stalls, overrun,
// back-to-back frames and asynchronous reset; follows FFT_OUT_BITREV_EN.
module tb_fft_out_serializer;
  localparam int N   = 32;
  localparam int MSB = 16;
  localparam int LW  = $clog2(N);

  logic             clk = 1'b0;
  logic             rst_n;
  logic             data_valid;
  logic [N*MSB-1:0] fft_data_in;
  logic             out_ready;
  logic [MSB-1:0]   out_data;
  logic             out_valid;
  logic [LW-1:0]    out_index;
  logic             out_last;
  logic             busy;
  logic             overrun;

  int total = 0;
  int bad   = 0;

  fft_out_serializer #(.N(N), .MSB(MSB)) dut (
    .clk(clk), .rst_n(rst_n), .data_valid(data_valid), .fft_data_in(fft_data_in),
    .out_ready(out_ready), .out_data(out_data), .out_valid(out_valid),
    .out_index(out_index), .out_last(out_last), .busy(busy), .overrun(overrun)
  );

  always #5 clk = ~clk;

  function automatic int exp_idx(input int k);
`ifdef FFT_OUT_BITREV_EN
    int r;
    r = 0;
    for (int b = 0; b < LW; b++) if (k & (1 << b)) r |= 1 << (LW-1-b);
    return r;
`else
    return k;
`endif
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Checks the k-th streamed word of a frame whose word j is base+j.
  task automatic chk_word(input string tag, input int base, input int k);
    chk({tag, ".valid"}, {31'd0, out_valid}, 32'd1);
    chk({tag, ".data"},  {16'd0, out_data},  32'(base + exp_idx(k)));
    chk({tag, ".index"}, 32'(out_index),     32'(exp_idx(k)));
    chk({tag, ".last"},  {31'd0, out_last},  32'(k == N-1));
  endtask

  task automatic set_frame(input int base);
    for (int k = 0; k < N; k++) fft_data_in[k*MSB +: MSB] = MSB'(base + k);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, ".valid"}, {31'd0, out_valid}, 32'd0);
    chk({tag, ".busy"},  {31'd0, busy},      32'd0);
    chk({tag, ".last"},  {31'd0, out_last},  32'd0);
  endtask

  // Pulses data_valid for one edge with the frame base+k, then scrambles the input bus.
  task automatic capture(input int base);
    set_frame(base);
    data_valid = 1'b1;
    step();
    data_valid = 1'b0;
    set_frame(16'hEE00);
  endtask

  initial begin
    int cyc;
    int n;
    rst_n = 1'b0; data_valid = 1'b0; out_ready = 1'b0; fft_data_in = '0;
    #12;
    chk("rst.valid",   {31'd0, out_valid}, 32'd0);
    chk("rst.busy",    {31'd0, busy},      32'd0);
    chk("rst.overrun", {31'd0, overrun},   32'd0);
    chk("rst.data",    {16'd0, out_data},  32'd0);
    chk("rst.index",   32'(out_index),     32'd0);
    chk("rst.last",    {31'd0, out_last},  32'd0);
    @(negedge clk); rst_n = 1'b1;
    step();

    // Full-rate stream; input bus scrambled after capture.
    out_ready = 1'b1;
    capture(16'h1000);
    for (int k = 0; k < N; k++) begin
      chk_word("full", 16'h1000, k);
      chk("full.busy", {31'd0, busy}, 32'd1);
      step();
    end
    chk_idle("full.end");
    step();
    chk_idle("full.end2");

    // out_ready toggling 1/0: 63 cycles, stable words in stall cycles.
    out_ready = 1'b1;
    capture(16'h1000);
    cyc = 0; n = 0;
    while (n < N && cyc < 100) begin
      out_ready = (cyc % 2 == 0);
      chk_word("stall", 16'h1000, n);
      if (out_ready) n++;
      cyc++;
      step();
    end
    chk("stall.cycles", 32'(cyc), 32'd63);
    chk_idle("stall.end");
    out_ready = 1'b1;

    // Second pulse mid-frame: ignored, sets overrun.
    capture(16'h1000);
    for (int k = 0; k < N; k++) begin
      chk_word("ovr", 16'h1000, k);
      if (k == 10) begin
        set_frame(16'h2000);
        data_valid = 1'b1;
      end
      step();
      data_valid = 1'b0;
      if (k >= 10) chk("ovr.flag", {31'd0, overrun}, 32'd1);
    end
    chk_idle("ovr.end");
    chk("ovr.sticky", {31'd0, overrun}, 32'd1);

    // Reset at word 5 clears everything without waiting for an edge.
    capture(16'h1000);
    for (int k = 0; k < 5; k++) step();
    chk_word("mid.w5", 16'h1000, 5);
    #2 rst_n = 1'b0;
    #1;
    chk_idle("arst");
    chk("arst.overrun", {31'd0, overrun},   32'd0);
    chk("arst.data",    {16'd0, out_data},  32'd0);
    chk("arst.index",   32'(out_index),     32'd0);
    step();
    @(negedge clk); rst_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step();
      chk_idle("post_rst");
    end

    // Pulse on the first edge after reset release, then back-to-back on word 31.
    rst_n = 1'b0;
    #2;
    set_frame(16'h1000);
    data_valid = 1'b1;
    @(negedge clk); rst_n = 1'b1;
    step();
    data_valid = 1'b0;
    set_frame(16'hEE00);
    for (int k = 0; k < N; k++) begin
      chk_word("b2b.a", 16'h1000, k);
      if (k == N-1) begin
        set_frame(16'h2000);
        data_valid = 1'b1;
      end
      step();
      data_valid = 1'b0;
    end
    set_frame(16'hEE00);
    for (int k = 0; k < N; k++) begin
      chk_word("b2b.b", 16'h2000, k);
      chk("b2b.overrun", {31'd0, overrun}, 32'd0);
      step();
    end
    chk_idle("b2b.end");
    chk("b2b.overrun_end", {31'd0, overrun}, 32'd0);

    // Plain k-valued frame: out_data tracks out_index.
    capture(0);
    for (int k = 0; k < N; k++) begin
      chk_word("kval", 0, k);
      step();
    end
    chk_idle("kval.end");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule
